// File: rtl/lsu_wb_pkg.sv
// lsu_wb_pkg: shared FSM state, lsu_op field positions and byte-lane mask helper.
package lsu_wb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam int OP_STORE = 3;
  localparam int OP_UNS = 2;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    return (size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF) << off;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane shift/mask and load lane extract with sign/zero extension.
module lsu_lane_align
  import lsu_wb_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]   i_off,
  input  logic [1:0]      i_size,
  input  logic            i_uns,
  input  logic [XLEN-1:0] i_wsrc,
  input  logic [XLEN-1:0] i_rdata,
  output logic [NB-1:0]   o_wmask,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);
  localparam logic [XLEN-1:0] ONES = '1;
  logic [OW+2:0]   w_sh_amt;
  logic [XLEN-1:0] w_sh, w_lm, w_top;
  logic [6:0]      w_nb;
  assign w_sh_amt = {i_off, 3'b000};
  // bytes shifted past the top lane fall off the truncated mask
  assign o_wmask = NB'(lane_mask(i_size, 3'(i_off)));
  assign o_wdata = i_wsrc << w_sh_amt;
  assign w_sh = i_rdata >> w_sh_amt;
  assign w_nb = i_size == SZ_B ? 7'd8 : i_size == SZ_H ? 7'd16 : i_size == SZ_W ? 7'd32 : 7'(XLEN);
  assign w_lm = ONES >> (7'(XLEN) - w_nb);
  assign w_top = w_lm & ~(w_lm >> 1);
  assign o_rdata = (w_sh & w_lm) | ((!i_uns && (|(w_sh & w_top))) ? ~w_lm : '0);
endmodule

// File: rtl/lsu_wb_unit.sv
// lsu_wb_unit: memory-access/writeback stage with bounded memory wait and bus error.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned H/W/D accesses without a request.
module lsu_wb_unit
  import lsu_wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rd_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [3:0]      lsu_op,
  input  logic            lsu_sel,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [NB-1:0]   mem_wmask,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic            bus_err
);
  state_t r_state, w_nxt;
  logic [XLEN-1:0] r_addr, r_wd, r_wb, w_ld, w_res;
  logic [3:0]      r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]      w_size;
  logic            r_err, w_cap, w_res_err, w_mis, w_to;
  assign w_size = (XLEN == 32 && r_op[1:0] == SZ_D) ? SZ_W : r_op[1:0];
`ifdef LSU_MISALIGN_CHECK_EN
  logic [1:0] w_in_size;
  assign w_in_size = (XLEN == 32 && lsu_op[1:0] == SZ_D) ? SZ_W : lsu_op[1:0];
  assign w_mis = (w_in_size == SZ_H && rd_data[0]) || (w_in_size == SZ_W && (|rd_data[1:0]))
              || (w_in_size == SZ_D && (|rd_data[2:0]));
`else
  assign w_mis = 1'b0;
`endif
  assign w_to = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));
  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .i_off  (r_addr[OW-1:0]),
    .i_size (w_size),
    .i_uns  (r_op[OP_UNS]),
    .i_wsrc (r_wd),
    .i_rdata(mem_rdata),
    .o_wmask(mem_wmask),
    .o_wdata(mem_wdata),
    .o_rdata(w_ld)
  );
  assign in_ready = r_state == IDLE;
  assign mem_req = r_state == REQ;
  assign mem_we = mem_req && r_op[OP_STORE];
  assign mem_addr = {r_addr[XLEN-1:OW], {OW{1'b0}}};
  assign out_valid = r_state == DONE;
  assign wb_data = r_wb;
  assign bus_err = r_err;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_nxt;
  // ack wins over timeout; timeout wins over a bare grant so the counter never overruns
  always_comb begin
    w_nxt = r_state;
    w_cap = 1'b0;
    w_res_err = 1'b0;
    w_res = '0;
    case (r_state)
      IDLE: if (in_valid) begin
        w_nxt = (lsu_sel && !w_mis) ? REQ : DONE;
        w_cap = !lsu_sel || w_mis;
        w_res = lsu_sel ? '0 : rd_data;
        w_res_err = lsu_sel && w_mis;
      end
      REQ, WAIT: if (mem_ack && (mem_gnt || r_state == WAIT)) begin
        w_nxt = DONE;
        w_cap = 1'b1;
        w_res = r_op[OP_STORE] ? '0 : w_ld;
      end else if (w_to) begin
        w_nxt = DONE;
        w_cap = 1'b1;
        w_res_err = 1'b1;
      end else if (r_state == REQ && mem_gnt) w_nxt = WAIT;
      DONE: if (out_ready) w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_wd <= '0;
      r_op <= '0;
      r_wb <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (in_valid && in_ready) begin
        r_addr <= rd_data;
        r_wd <= rs2_data;
        r_op <= lsu_op;
      end
      if (w_cap) begin
        r_wb <= w_res;
        r_err <= w_res_err;
      end else if (out_valid && out_ready) r_err <= 1'b0;
      r_cnt <= (r_state == IDLE) ? '0 : (r_state == REQ || r_state == WAIT) ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule
